mix_slot_sched: RTL

Sample-rate scheduler for the audio mixer datapath. It holds a programmable clock-enable divider that marks each sample period. On every period boundary it walks the enabled input channels in ascending index order, and issues one valid/ready slot per channel to the shared mix accumulator. It flags frame completion and overruns, i.e. a new sample tick arriving while the previous frame is still in progress.

---
 rtl/mix_slot_sched_pkg.sv | 19 +
 rtl/mix_slot_sched_tick_gen.sv | 24 ++
 rtl/mix_slot_sched.sv | 94 +++++++++
 3 files changed

// File: rtl/mix_slot_sched_pkg.sv
// mix_sched_pkg: shared state encoding, overrun counter width and lowest-set-bit helper
package mix_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } sched_state_t;

    localparam int OVRCNT_W = 8;

    // Masks up to 16 channels; callers zero-extend and truncate the index.
    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = '0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) lowest_set = 4'(i);
    endfunction

endpackage

// File: rtl/mix_slot_sched_tick_gen.sv
// tick_gen: programmable clock-enable divider, one tick every lim+1 cycles while run is high
module tick_gen #(
    parameter int BITLEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITLEN-1:0] lim,
    input  logic              run,
    output logic              tick
);

    logic [BITLEN-1:0] ctr;

    // >= so that lowering lim below the running count wraps at once
    assign tick = run && (ctr >= lim);

    always_ff @(posedge clk) begin
        if (rst || !run || tick)
            ctr <= '0;
        else
            ctr <= ctr + BITLEN'(1);
    end

endmodule

// File: rtl/mix_slot_sched.sv
// mix_slot_sched: per-sample-period walk of enabled channels into valid/ready mixer slots.
// Optional MIX_SCHED_OVRCNT_EN adds a saturating overrun counter output ovr_count.
module mix_slot_sched
    import mix_sched_pkg::*;
#(
    parameter int BITLEN = 8,
    parameter int NCH    = 4,
    parameter int CHW    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITLEN-1:0] lim,
    input  logic              run,
    input  logic [NCH-1:0]    ch_mask,
    output logic              tick,
    output logic              slot_valid,
    output logic [CHW-1:0]    slot_ch,
    output logic              slot_first,
    input  logic              slot_ready,
    output logic              frame_done,
    output logic              busy,
    output logic              overrun
`ifdef MIX_SCHED_OVRCNT_EN
    ,
    output logic [OVRCNT_W-1:0] ovr_count
`endif
);

    sched_state_t   state, state_n;
    logic [NCH-1:0] pend, pend_n, rem;
    logic [CHW-1:0] ch_n;
    logic           first_n;

    tick_gen #(.BITLEN(BITLEN)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .lim  (lim),
        .run  (run),
        .tick (tick)
    );

    assign slot_valid = state == ISSUE;
    assign frame_done = state == DONE;
    assign busy       = state != IDLE;
    assign overrun    = tick && busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend       <= '0;
            slot_ch    <= '0;
            slot_first <= 1'b0;
        end else begin
            state      <= state_n;
            pend       <= pend_n;
            slot_ch    <= ch_n;
            slot_first <= first_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        ch_n    = slot_ch;
        first_n = slot_first;
        rem     = pend & ~(NCH'(1) << slot_ch);
        unique case (state)
            IDLE: if (tick) begin
                pend_n  = ch_mask;
                state_n = |ch_mask ? ISSUE : DONE;
                ch_n    = |ch_mask ? CHW'(lowest_set(16'(ch_mask))) : slot_ch;
                first_n = |ch_mask;
            end
            ISSUE: if (slot_ready) begin
                pend_n  = rem;
                first_n = 1'b0;
                state_n = |rem ? ISSUE : DONE;
                ch_n    = |rem ? CHW'(lowest_set(16'(rem))) : slot_ch;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef MIX_SCHED_OVRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            ovr_count <= '0;
        else if (overrun && ovr_count != '1)
            ovr_count <= ovr_count + OVRCNT_W'(1);
    end
`endif

endmodule
